// File: rtl/smg_scan_module.sv
// Six-digit multiplexed common-anode 7-segment driver.
// Latches the BCD word once per frame and scans one digit per dwell period.
module smg_scan_module #(
    parameter logic [15:0] T_SCAN   = 16'd49_999,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Number_Sig,
    input  logic [5:0]  Dp_Sig,
    output logic [7:0]  SMG_Data,
    output logic [5:0]  Scan_Sig,
    output logic        Frame_Done
);

    logic [15:0] c1_reg;
    logic [2:0]  digit_reg;
    logic [23:0] rnum_reg;
    logic [5:0]  rdp_reg;

    logic        tick;
    logic        frame_end;
    logic [3:0]  nib [6];
    logic [6:0]  seg_digit [6];
    logic [5:0]  lz_blank;
    logic [5:0]  scan_next;
    logic [6:0]  seg_next;
    logic        dp_next;

    assign tick      = (c1_reg == T_SCAN);
    assign frame_end = tick && (digit_reg == 3'd5);

    // Segment pattern with bits 6:0 = g..a, active-low; dp is added separately.
    function automatic logic [6:0] seg7(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign nib[gi] = rnum_reg[4*gi +: 4];
            if (gi == 0) begin : g_units
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                // A digit is a leading zero when it and everything above it is zero.
                assign lz_blank[gi] = BLANK_LZ && (rnum_reg[23:4*gi] == '0);
            end
            assign seg_digit[gi] = lz_blank[gi] ? 7'h7F : seg7(nib[gi]);
            assign scan_next[gi] = (digit_reg != 3'(gi));
        end
    endgenerate

    always_comb begin
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (digit_reg == 3'(i)) begin
                seg_next = seg_digit[i];
                dp_next  = ~rdp_reg[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            c1_reg     <= '0;
            digit_reg  <= '0;
            rnum_reg   <= '0;
            rdp_reg    <= '0;
            SMG_Data   <= 8'hFF;
            Scan_Sig   <= 6'h3F;
            Frame_Done <= 1'b0;
        end else begin
            c1_reg <= tick ? 16'd0 : c1_reg + 16'd1;

            if (digit_reg > 3'd5) begin
                digit_reg <= 3'd0;
            end else if (tick) begin
                digit_reg <= (digit_reg == 3'd5) ? 3'd0 : digit_reg + 3'd1;
            end

            // Snapshot only at the frame boundary so a frame never mixes two words.
            if (frame_end) begin
                rnum_reg <= Number_Sig;
                rdp_reg  <= Dp_Sig;
            end
            Frame_Done <= frame_end;

            SMG_Data <= {dp_next, seg_next};
            Scan_Sig <= scan_next;
        end
    end

endmodule

// File: tb/tb_smg_scan_module.sv
// Bench for smg_scan_module: two instances (blanking on/off) against a cycle-count based model.
module tb_smg_scan_module;

    localparam int DWELL = 4;
    localparam int FRAME = 6 * DWELL;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [23:0] num;
    logic [5:0]  dp;
    logic [7:0]  smg_b, smg_n;
    logic [5:0]  scan_b, scan_n;
    logic        fd_b, fd_n;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cyc = 0;
    logic [23:0] snap_num = '0;
    logic [5:0]  snap_dp  = '0;

    always #5 CLK = ~CLK;

    smg_scan_module #(.T_SCAN(16'd3), .BLANK_LZ(1'b1)) dut_blank (
        .CLK(CLK), .RSTn(RSTn), .Number_Sig(num), .Dp_Sig(dp),
        .SMG_Data(smg_b), .Scan_Sig(scan_b), .Frame_Done(fd_b)
    );

    smg_scan_module #(.T_SCAN(16'd3), .BLANK_LZ(1'b0)) dut_plain (
        .CLK(CLK), .RSTn(RSTn), .Number_Sig(num), .Dp_Sig(dp),
        .SMG_Data(smg_n), .Scan_Sig(scan_n), .Frame_Done(fd_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Expected pins for digit k of a snapshot.
    function automatic logic [7:0] ref_seg(input logic [23:0] v, input logic [5:0] p,
                                           input int k, input bit blank);
        int         upper;
        logic [7:0] s;
        upper = int'(v) >> (4 * k);
        if (blank && k > 0 && upper == 0) s = 8'hFF;
        else                              s = glyph(upper % 16);
        if (p[k]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic do_reset(input int cycles);
        RSTn = 1'b0;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            check("rst_smg_lz1",  32'(smg_b),  32'hFF);
            check("rst_scan_lz1", 32'(scan_b), 32'h3F);
            check("rst_fd_lz1",   32'(fd_b),   32'h0);
            check("rst_smg_lz0",  32'(smg_n),  32'hFF);
            check("rst_fd_lz0",   32'(fd_n),   32'h0);
            $display("reset cycle: smg=%h scan=%h fd=%b", smg_b, scan_b, fd_b);
        end
        RSTn     = 1'b1;
        n_cyc    = 0;
        snap_num = '0;
        snap_dp  = '0;
    endtask

    // One clock: outputs after edge n show digit ((n-1)/DWELL)%6 of the word
    // captured at the last frame boundary before that edge.
    task automatic step();
        int         d;
        logic [7:0] e_b, e_n;
        logic [5:0] e_scan;
        logic       e_fd;
        @(posedge CLK);
        n_cyc++;
        d      = ((n_cyc - 1) / DWELL) % 6;
        e_b    = ref_seg(snap_num, snap_dp, d, 1'b1);
        e_n    = ref_seg(snap_num, snap_dp, d, 1'b0);
        e_scan = ~(6'b1 << d);
        e_fd   = (n_cyc % FRAME == 0);
        if (e_fd) begin
            snap_num = num;
            snap_dp  = dp;
        end
        #1;
        check("smg_lz1",  32'(smg_b),  32'(e_b));
        check("scan_lz1", 32'(scan_b), 32'(e_scan));
        check("fd_lz1",   32'(fd_b),   32'(e_fd));
        check("smg_lz0",  32'(smg_n),  32'(e_n));
        check("scan_lz0", 32'(scan_n), 32'(e_scan));
        check("fd_lz0",   32'(fd_n),   32'(e_fd));
        $display("cyc %0d digit %0d: scan=%h smg_lz1=%h smg_lz0=%h fd=%b", n_cyc, d, scan_b, smg_b, smg_n, fd_b);
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic to_frame();
        step();
        while (n_cyc % FRAME != 0) step();
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] mask;
        RSTn = 1'b0;
        num  = '0;
        dp   = '0;

        do_reset(5);
        run(30);

        num = 24'h123456;           to_frame(); run(48);
        num = 24'h000042;           to_frame(); run(24);
        num = 24'h000000;           to_frame(); run(24);

        num = 24'h111111;           to_frame(); run(10);
        num = 24'h999999;           to_frame(); run(24);

        num = 24'h00000A;           to_frame(); run(24);
        num = 24'h000005; dp = 6'b000001; to_frame(); run(24);
        num = 24'h000000; dp = 6'b000100; to_frame(); run(24);

        num = 24'h654321; dp = 6'b000000; to_frame(); run(13);
        do_reset(1);
        run(30);

        repeat (25) begin
            r    = $urandom;
            mask = 24'hFFFFFF >> (4 * $urandom_range(0, 5));
            num  = r[23:0] & mask;
            r    = $urandom;
            dp   = r[5:0];
            run($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
        end
        to_frame();
        run(24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
